mac_cfg_sequencer: RTL and testbench

- Parametrised MAC register-initialisation sequencer: walks an external N-entry (address, data) table and writes each entry into the MAC register port using the reg_busy handshake.
- Optional read-back verify per entry, per-access timeout, bounded retry, restart on demand, and error reporting.
- Sits between the board-level reset/control logic and the MAC register interface.
- Generalises the fixed 11-entry single-shot reset writer.

---
 rtl/mac_cfg_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_mac_cfg_sequencer.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_cfg_sequencer.sv
// MAC register-init sequencer: walks an (addr, data) table into the MAC port.
// Ports: tbl_* ROM lookup, reg_* MAC access, seq_* status, err_* abort info.
module mac_cfg_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int N_ENTRIES  = 11,
  parameter int IDX_W      = 6,
  parameter int TIMEOUT    = 1023,
  parameter int MAX_RETRY  = 2,
  parameter bit AUTO_START = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              verify_en,
  output logic [IDX_W-1:0]  tbl_idx,
  input  logic [ADDR_W-1:0] tbl_addr,
  input  logic [DATA_W-1:0] tbl_data,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_writedata,
  input  logic [DATA_W-1:0] reg_readdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic              reg_busy,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              seq_error,
  output logic [IDX_W-1:0]  err_idx,
  output logic [1:0]        err_code
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_WAIT,
    S_RD_REQ,
    S_RD_WAIT,
    S_CHECK,
    S_NEXT,
    S_RETRY,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [2:0]       MAX_R    = 3'(MAX_RETRY);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t state, nxt;

  logic [IDX_W-1:0]  idx;
  logic [2:0]        retry;
  logic [15:0]       cnt;
  logic              busy_d;
  logic              ver_q;
  logic              auto_q;
  logic              last_q;
  logic [DATA_W-1:0] rd_q;

  logic idle_st;
  logic go;
  logic tmo;
  logic fall;
  logic fail_tmo;
  logic fail_mis;

  assign idle_st = (state == S_IDLE) || (state == S_DONE) ||
                   (state == S_ERROR);
  assign go      = idle_st && (start || auto_q);
  assign tmo     = (cnt == TMO_LAST);
  // busy_d is only 1 here once the rise was seen in this access
  assign fall    = busy_d && !reg_busy;
  assign tbl_idx = idx;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // next-state logic
  always_comb begin
    nxt      = state;
    fail_tmo = 1'b0;
    fail_mis = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (go) nxt = S_WR_REQ;
      end
      S_WR_REQ: begin
        if (reg_busy) nxt = S_WR_WAIT;
        else if (tmo) fail_tmo = 1'b1;
      end
      S_WR_WAIT: begin
        if (fall) nxt = ver_q ? S_RD_REQ : S_NEXT;
        else if (tmo) fail_tmo = 1'b1;
      end
      S_RD_REQ: begin
        if (reg_busy) nxt = S_RD_WAIT;
        else if (tmo) fail_tmo = 1'b1;
      end
      S_RD_WAIT: begin
        if (fall) nxt = S_CHECK;
        else if (tmo) fail_tmo = 1'b1;
      end
      S_CHECK: begin
        if (rd_q == reg_writedata) nxt = S_NEXT;
        else fail_mis = 1'b1;
      end
      S_NEXT:  nxt = last_q ? S_DONE : S_WR_REQ;
      S_RETRY: nxt = S_WR_REQ;
      default: nxt = S_IDLE;
    endcase
    if (fail_tmo || fail_mis)
      nxt = (retry < MAX_R) ? S_RETRY : S_ERROR;
  end

  // outputs
  always_comb begin
    reg_wr   = 1'b0;
    reg_rd   = 1'b0;
    seq_busy = !idle_st;
    unique case (state)
      S_WR_REQ, S_WR_WAIT: reg_wr = 1'b1;
      S_RD_REQ, S_RD_WAIT: reg_rd = 1'b1;
      default: ;
    endcase
  end

  // datapath and status
  always_ff @(posedge clk) begin
    if (rst) begin
      idx           <= '0;
      retry         <= '0;
      cnt           <= '0;
      busy_d        <= 1'b0;
      ver_q         <= 1'b0;
      auto_q        <= AUTO_START;
      last_q        <= 1'b0;
      rd_q          <= '0;
      reg_addr      <= '0;
      reg_writedata <= '0;
      seq_done      <= 1'b0;
      seq_error     <= 1'b0;
      err_idx       <= '0;
      err_code      <= 2'b00;
    end else begin
      busy_d <= reg_busy;

      if (nxt != state)       cnt <= '0;
      else if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;

      if (go) begin
        auto_q    <= 1'b0;
        ver_q     <= verify_en;
        seq_done  <= 1'b0;
        seq_error <= 1'b0;
        err_code  <= 2'b00;
        err_idx   <= '0;
        retry     <= '0;
        idx       <= '0;
        last_q    <= 1'b0;
      end

      // idx is 0 while idle and advanced on NEXT entry, so the
      // ROM already shows the entry being loaded here
      if (nxt == S_WR_REQ && state != S_WR_REQ) begin
        reg_addr      <= tbl_addr;
        reg_writedata <= tbl_data;
      end

      if (state == S_RD_WAIT && fall) rd_q <= reg_readdata;

      if (nxt == S_NEXT && state != S_NEXT) begin
        if (idx == LAST_IDX) last_q <= 1'b1;
        else                 idx    <= idx + IDX_ONE;
      end

      if (state == S_NEXT) begin
        retry <= '0;
        if (last_q) begin
          seq_done <= 1'b1;
          last_q   <= 1'b0;
          idx      <= '0;
        end
      end

      if (nxt == S_RETRY) retry <= retry + 3'd1;

      if (nxt == S_ERROR && state != S_ERROR) begin
        seq_error <= 1'b1;
        err_idx   <= idx;
        err_code  <= fail_tmo ? 2'b01 : 2'b10;
        idx       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mac_cfg_sequencer.sv
// Bench for mac_cfg_sequencer: bus model + write scoreboard.
// Scenarios: reset, auto-run, verify/restart, mismatch, timeout, mid reset.
module tb_mac_cfg_sequencer;

  localparam int N = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        verify_en = 1'b0;
  logic [5:0]  tbl_idx;
  logic [7:0]  tbl_addr;
  logic [31:0] tbl_data;
  logic [7:0]  reg_addr;
  logic [31:0] reg_writedata;
  logic [31:0] reg_readdata;
  logic        reg_wr;
  logic        reg_rd;
  logic        reg_busy;
  logic        seq_busy;
  logic        seq_done;
  logic        seq_error;
  logic [5:0]  err_idx;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  mac_cfg_sequencer #(
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .verify_en(verify_en),
    .tbl_idx(tbl_idx),
    .tbl_addr(tbl_addr),
    .tbl_data(tbl_data),
    .reg_addr(reg_addr),
    .reg_writedata(reg_writedata),
    .reg_readdata(reg_readdata),
    .reg_wr(reg_wr),
    .reg_rd(reg_rd),
    .reg_busy(reg_busy),
    .seq_busy(seq_busy),
    .seq_done(seq_done),
    .seq_error(seq_error),
    .err_idx(err_idx),
    .err_code(err_code)
  );

  function automatic logic [7:0] ent_addr(input int i);
    if (i == 0)  return 8'd3;
    if (i == 10) return 8'd2;
    return 8'(i + 16);
  endfunction

  function automatic logic [31:0] ent_data(input int i);
    logic [31:0] d;
    if (i == 0)  return 32'h06150910;
    if (i == 10) return 32'h04000033;
    d = 32'hC0DE0000;
    d[15:0] = 16'(i * 257);
    return d;
  endfunction

  assign tbl_addr = ent_addr(int'(tbl_idx));
  assign tbl_data = ent_data(int'(tbl_idx));

  // bus model / monitor
  logic        busy_r = 1'b0;
  logic [1:0]  bcnt = 2'd0;
  logic        prev_wr = 1'b0;
  logic        prev_rd = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic [31:0] mem [256];
  int          no_busy_idx = -1;
  int          corrupt_idx = -1;
  logic [7:0]  obs_a [$];
  logic [31:0] obs_d [$];
  int          len_q [$];
  int          rd_cnt = 0;
  int          both_cnt = 0;
  int          wr_len = 0;

  assign reg_busy     = busy_r;
  assign reg_readdata = rdata;

  always @(posedge clk) begin
    if (rst) begin
      busy_r  <= 1'b0;
      bcnt    <= 2'd0;
      prev_wr <= 1'b0;
      prev_rd <= 1'b0;
      wr_len  <= 0;
    end else begin
      prev_wr <= reg_wr;
      prev_rd <= reg_rd;
      if (reg_wr && reg_rd) both_cnt <= both_cnt + 1;
      if (reg_wr) wr_len <= wr_len + 1;
      else if (prev_wr) begin
        len_q.push_back(wr_len);
        wr_len <= 0;
      end
      if (bcnt != 2'd0) begin
        bcnt <= bcnt - 2'd1;
        if (bcnt == 2'd1) busy_r <= 1'b0;
      end else if (reg_wr && !prev_wr) begin
        obs_a.push_back(reg_addr);
        obs_d.push_back(reg_writedata);
        mem[reg_addr] <= reg_writedata;
        if (int'(tbl_idx) != no_busy_idx) begin
          busy_r <= 1'b1;
          bcnt   <= 2'd3;
        end
      end else if (reg_rd && !prev_rd) begin
        rd_cnt <= rd_cnt + 1;
        if (int'(tbl_idx) == corrupt_idx) rdata <= mem[reg_addr] ^ 32'h1;
        else                              rdata <= mem[reg_addr];
        busy_r <= 1'b1;
        bcnt   <= 2'd3;
      end
    end
  end

  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_a [$];
  logic [31:0] exp_d [$];

  task automatic sb_push(input int i);
    exp_a.push_back(ent_addr(i));
    exp_d.push_back(ent_data(i));
  endtask

  task automatic wait_for(input logic want_err, input int limit,
                          output logic ok);
    ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (want_err ? seq_error : seq_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_start(input logic ver);
    @(negedge clk);
    verify_en = ver;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({reg_wr, reg_rd, seq_busy, seq_done, seq_error} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 00000",
               {reg_wr, reg_rd, seq_busy, seq_done, seq_error});
    end
    total++;
    if (tbl_idx !== 6'd0 || err_idx !== 6'd0 || err_code !== 2'b00) begin
      bad++;
      $display("FAIL reset_idx: got %0d/%0d/%b want 0/0/00",
               tbl_idx, err_idx, err_code);
    end
    total++;
    if (reg_addr !== 8'd0 || reg_writedata !== 32'd0) begin
      bad++;
      $display("FAIL reset_bus: got %h/%h want 0/0",
               reg_addr, reg_writedata);
    end
  endtask

  task automatic test_auto_seq();
    int base;
    int k;
    logic ok;
    logic [7:0] ea;
    logic [31:0] ed;
    base = obs_a.size();
    for (int i = 0; i < N; i++) sb_push(i);
    verify_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (seq_busy !== 1'b1 || reg_wr !== 1'b1 || reg_addr !== 8'd3) begin
      bad++;
      $display("FAIL auto_start: got busy=%b wr=%b addr=%h want 1 1 03",
               seq_busy, reg_wr, reg_addr);
    end
    wait_for(1'b0, 500, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL auto_done: got seq_done=%b want 1 within 500", seq_done);
    end
    repeat (3) @(negedge clk);
    total++;
    if (seq_error !== 1'b0 || reg_wr !== 1'b0 || seq_busy !== 1'b0) begin
      bad++;
      $display("FAIL auto_idle: got err=%b wr=%b busy=%b want 0 0 0",
               seq_error, reg_wr, seq_busy);
    end
    k = 0;
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front();
      ed = exp_d.pop_front();
      total++;
      if (base + k >= obs_a.size()) begin
        bad++;
        $display("FAIL auto_wr%0d: got none want %h/%h", k, ea, ed);
      end else if (obs_a[base+k] !== ea || obs_d[base+k] !== ed) begin
        bad++;
        $display("FAIL auto_wr%0d: got %h/%h want %h/%h", k,
                 obs_a[base+k], obs_d[base+k], ea, ed);
      end
      k++;
    end
    total++;
    if (obs_a.size() - base != N) begin
      bad++;
      $display("FAIL auto_count: got %0d want %0d", obs_a.size() - base, N);
    end
  endtask

  task automatic test_verify_restart();
    int base;
    int rb;
    int bb;
    int k;
    logic ok;
    logic [7:0] ea;
    logic [31:0] ed;
    base = obs_a.size();
    rb = rd_cnt;
    bb = both_cnt;
    for (int i = 0; i < N; i++) sb_push(i);
    pulse_start(1'b1);
    total++;
    if (seq_done !== 1'b0 || seq_busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_clear: got done=%b busy=%b want 0 1",
               seq_done, seq_busy);
    end
    repeat (20) @(negedge clk);
    pulse_start(1'b0);
    wait_for(1'b0, 1000, ok);
    total++;
    if (!ok || seq_error !== 1'b0) begin
      bad++;
      $display("FAIL verify_done: got done=%b err=%b want 1 0",
               seq_done, seq_error);
    end
    repeat (3) @(negedge clk);
    total++;
    if (rd_cnt - rb != N) begin
      bad++;
      $display("FAIL verify_reads: got %0d want %0d", rd_cnt - rb, N);
    end
    total++;
    if (both_cnt != bb) begin
      bad++;
      $display("FAIL verify_exclusive: got %0d overlaps want 0",
               both_cnt - bb);
    end
    k = 0;
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front();
      ed = exp_d.pop_front();
      total++;
      if (base + k >= obs_a.size()) begin
        bad++;
        $display("FAIL verify_wr%0d: got none want %h/%h", k, ea, ed);
      end else if (obs_a[base+k] !== ea || obs_d[base+k] !== ed) begin
        bad++;
        $display("FAIL verify_wr%0d: got %h/%h want %h/%h", k,
                 obs_a[base+k], obs_d[base+k], ea, ed);
      end
      k++;
    end
    total++;
    if (obs_a.size() - base != N) begin
      bad++;
      $display("FAIL verify_count: got %0d want %0d",
               obs_a.size() - base, N);
    end
  endtask

  task automatic test_mismatch();
    int base;
    int k;
    logic ok;
    logic [7:0] ea;
    logic [31:0] ed;
    corrupt_idx = 4;
    base = obs_a.size();
    for (int i = 0; i < 5; i++) sb_push(i);
    sb_push(4);
    sb_push(4);
    pulse_start(1'b1);
    wait_for(1'b1, 1000, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL mis_error: got seq_error=%b want 1", seq_error);
    end
    repeat (10) @(negedge clk);
    total++;
    if (err_idx !== 6'd4 || err_code !== 2'b10 || seq_done !== 1'b0) begin
      bad++;
      $display("FAIL mis_info: got idx=%0d code=%b done=%b want 4 10 0",
               err_idx, err_code, seq_done);
    end
    total++;
    if (reg_wr !== 1'b0 || reg_rd !== 1'b0 || seq_busy !== 1'b0) begin
      bad++;
      $display("FAIL mis_idle: got wr=%b rd=%b busy=%b want 0 0 0",
               reg_wr, reg_rd, seq_busy);
    end
    k = 0;
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front();
      ed = exp_d.pop_front();
      total++;
      if (base + k >= obs_a.size()) begin
        bad++;
        $display("FAIL mis_wr%0d: got none want %h/%h", k, ea, ed);
      end else if (obs_a[base+k] !== ea || obs_d[base+k] !== ed) begin
        bad++;
        $display("FAIL mis_wr%0d: got %h/%h want %h/%h", k,
                 obs_a[base+k], obs_d[base+k], ea, ed);
      end
      k++;
    end
    total++;
    if (obs_a.size() - base != 7) begin
      bad++;
      $display("FAIL mis_count: got %0d want 7", obs_a.size() - base);
    end
    corrupt_idx = -1;
  endtask

  task automatic test_timeout();
    int base;
    int lb;
    int k;
    logic ok;
    logic [7:0] ea;
    logic [31:0] ed;
    no_busy_idx = 2;
    base = obs_a.size();
    lb = len_q.size();
    sb_push(0);
    sb_push(1);
    sb_push(2);
    sb_push(2);
    sb_push(2);
    pulse_start(1'b0);
    wait_for(1'b1, 1000, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL tmo_error: got seq_error=%b want 1", seq_error);
    end
    repeat (4) @(negedge clk);
    total++;
    if (err_code !== 2'b01 || err_idx !== 6'd2) begin
      bad++;
      $display("FAIL tmo_info: got code=%b idx=%0d want 01 2",
               err_code, err_idx);
    end
    total++;
    if (reg_wr !== 1'b0 || seq_busy !== 1'b0) begin
      bad++;
      $display("FAIL tmo_idle: got wr=%b busy=%b want 0 0", reg_wr, seq_busy);
    end
    total++;
    if (len_q.size() - lb != 5) begin
      bad++;
      $display("FAIL tmo_pulses: got %0d want 5", len_q.size() - lb);
    end else begin
      for (int p = 2; p < 5; p++) begin
        total++;
        if (len_q[lb+p] != 15) begin
          bad++;
          $display("FAIL tmo_len%0d: got %0d want 15", p, len_q[lb+p]);
        end
      end
    end
    k = 0;
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front();
      ed = exp_d.pop_front();
      total++;
      if (base + k >= obs_a.size()) begin
        bad++;
        $display("FAIL tmo_wr%0d: got none want %h/%h", k, ea, ed);
      end else if (obs_a[base+k] !== ea || obs_d[base+k] !== ed) begin
        bad++;
        $display("FAIL tmo_wr%0d: got %h/%h want %h/%h", k,
                 obs_a[base+k], obs_d[base+k], ea, ed);
      end
      k++;
    end
    no_busy_idx = -1;
  endtask

  task automatic test_reset_mid();
    int base;
    int k;
    logic ok;
    logic hit;
    logic [7:0] ea;
    logic [31:0] ed;
    pulse_start(1'b0);
    hit = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (tbl_idx == 6'd6 && reg_wr && reg_busy) begin
        hit = 1'b1;
        break;
      end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL mid_reach: got idx=%0d want write of entry 6", tbl_idx);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({reg_wr, reg_rd, seq_busy, seq_done, seq_error} !== 5'b0 ||
        tbl_idx !== 6'd0 || reg_addr !== 8'd0 || reg_writedata !== 32'd0) begin
      bad++;
      $display("FAIL mid_reset: got %b idx=%0d addr=%h data=%h want zeros",
               {reg_wr, reg_rd, seq_busy, seq_done, seq_error},
               tbl_idx, reg_addr, reg_writedata);
    end
    base = obs_a.size();
    for (int i = 0; i < N; i++) sb_push(i);
    rst = 1'b0;
    wait_for(1'b0, 500, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL mid_done: got seq_done=%b want 1", seq_done);
    end
    repeat (3) @(negedge clk);
    k = 0;
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front();
      ed = exp_d.pop_front();
      total++;
      if (base + k >= obs_a.size()) begin
        bad++;
        $display("FAIL mid_wr%0d: got none want %h/%h", k, ea, ed);
      end else if (obs_a[base+k] !== ea || obs_d[base+k] !== ed) begin
        bad++;
        $display("FAIL mid_wr%0d: got %h/%h want %h/%h", k,
                 obs_a[base+k], obs_d[base+k], ea, ed);
      end
      k++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_auto_seq();
    test_verify_restart();
    test_mismatch();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
